// File: rtl/lfsr_sseg_top.sv
// LFSR demo top: a rate-selectable prescaler steps a 16-bit Fibonacci LFSR. The LFSR
// value or its step count is scanned onto a 4-digit common-anode 7-segment display.
module lfsr_sseg_top #(
    parameter int          DIV_BASE     = 26,
    parameter int          REFRESH_BITS = 16,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dispToggle,
    input  logic [2:0] clkscale,
    output logic [7:0] sseg,
    output logic [3:0] an
);

    logic [31:0]             presc_q;
    logic [15:0]             lfsr_q;
    logic [15:0]             step_q;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [1:0]              idx_q;

    logic [31:0] term;
    logic        tick;
    logic        fb;
    logic [15:0] disp_val;
    logic [3:0]  nibble;
    logic [7:0]  seg_raw;
    logic [7:0]  seg_rst;
    logic [7:0]  sseg_d;
    logic [3:0]  an_d;
    int          sh;

    function automatic logic [7:0] hex7(input logic [3:0] d);
        logic [7:0] s;
        unique case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Compare with >= so a rate change below the current count ticks at once.
    always_comb begin
        sh = DIV_BASE - 3 * int'(clkscale);
        if (sh <= 0) begin
            term = 32'd0;
        end else begin
            term = (32'd1 << sh) - 32'd1;
        end
        tick = (presc_q >= term);
        fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end

    always_comb begin
        disp_val = dispToggle ? step_q : lfsr_q;
        case (idx_q)
            2'd0: begin nibble = disp_val[3:0];   an_d = 4'b1110; end
            2'd1: begin nibble = disp_val[7:4];   an_d = 4'b1101; end
            2'd2: begin nibble = disp_val[11:8];  an_d = 4'b1011; end
            default: begin nibble = disp_val[15:12]; an_d = 4'b0111; end
        endcase
        seg_raw = hex7(nibble);
        sseg_d  = {1'b1, seg_raw[6:0]};
        seg_rst = hex7(SEED[3:0]);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q   <= 32'd0;
            lfsr_q    <= SEED;
            step_q    <= 16'd0;
            refresh_q <= '0;
            idx_q     <= 2'd0;
            an        <= 4'b1110;
            sseg      <= {1'b1, seg_rst[6:0]};
        end else begin
            presc_q <= tick ? 32'd0 : presc_q + 32'd1;
            if (tick) begin
                lfsr_q <= (lfsr_q == 16'd0) ? SEED : {lfsr_q[14:0], fb};
                step_q <= step_q + 16'd1;
            end
            refresh_q <= refresh_q + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
            if (&refresh_q) begin
                idx_q <= idx_q + 2'd1;
            end
            an   <= an_d;
            sseg <= sseg_d;
        end
    end

endmodule

// File: tb/tb_lfsr_sseg_top.sv
// Directed bench for lfsr_sseg_top: reset, LFSR stepping, digit scan, display select,
// rate change mid-count, mid-run reset and a full-period run on a fast second instance.
module tb_lfsr_sseg_top;

    logic       clk = 1'b0;
    logic       reset;
    logic       dispToggle;
    logic [2:0] clkscale;
    logic [7:0] sseg;
    logic [3:0] an;

    logic       reset2;
    logic [7:0] sseg2;
    logic [3:0] an2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lfsr_sseg_top #(.DIV_BASE(26), .REFRESH_BITS(2), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .reset      (reset),
        .dispToggle (dispToggle),
        .clkscale   (clkscale),
        .sseg       (sseg),
        .an         (an)
    );

    // DIV_BASE 21 with clkscale 7 ticks every cycle, making a full period affordable.
    lfsr_sseg_top #(.DIV_BASE(21), .REFRESH_BITS(2), .SEED(16'hACE1)) dut2 (
        .clk        (clk),
        .reset      (reset2),
        .dispToggle (1'b0),
        .clkscale   (3'd7),
        .sseg       (sseg2),
        .an         (an2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen_zero;
        logic [15:0] l2;
        reset      = 1'b0;
        reset2     = 1'b0;
        dispToggle = 1'b0;
        clkscale   = 3'd7;
        step(5);
        check("rst_an",   {28'd0, an},         32'h0000_000E);
        check("rst_sseg", {24'd0, sseg},       32'h0000_00F9);
        check("rst_lfsr", {16'd0, dut.lfsr_q}, 32'h0000_ACE1);
        check("rst_step", {16'd0, dut.step_q}, 32'h0000_0000);

        // Edge count k after release: k=32 first tick, k=64 second.
        reset = 1'b1;
        step(31);
        check("pre_tick1", {16'd0, dut.lfsr_q}, 32'h0000_ACE1);
        step(1);
        check("tick1_lfsr", {16'd0, dut.lfsr_q}, 32'h0000_59C3);
        check("tick1_step", {16'd0, dut.step_q}, 32'h0000_0001);
        step(32);
        check("tick2_lfsr", {16'd0, dut.lfsr_q}, 32'h0000_B387);
        check("tick2_step", {16'd0, dut.step_q}, 32'h0000_0002);

        // Scan of B387: digit index before edge k is ((k-1)/4)%4.
        step(4);
        check("d0_an",   {28'd0, an},   32'h0000_000E);
        check("d0_sseg", {24'd0, sseg}, 32'h0000_00F8);
        step(4);
        check("d1_an",   {28'd0, an},   32'h0000_000D);
        check("d1_sseg", {24'd0, sseg}, 32'h0000_0080);
        step(4);
        check("d2_an",   {28'd0, an},   32'h0000_000B);
        check("d2_sseg", {24'd0, sseg}, 32'h0000_00B0);
        step(4);
        check("d3_an",   {28'd0, an},   32'h0000_0007);
        check("d3_sseg", {24'd0, sseg}, 32'h0000_0083);

        // k=80: show step counter (=2).
        dispToggle = 1'b1;
        step(4);
        check("stp_d0_an",   {28'd0, an},   32'h0000_000E);
        check("stp_d0_sseg", {24'd0, sseg}, 32'h0000_00A4);
        step(4);
        check("stp_d1_sseg", {24'd0, sseg}, 32'h0000_00C0);
        step(7);
        check("tgl_pre_tick3", {16'd0, dut.lfsr_q}, 32'h0000_B387);
        step(1);
        check("tick3_lfsr", {16'd0, dut.lfsr_q}, 32'h0000_670F);
        check("tick3_step", {16'd0, dut.step_q}, 32'h0000_0003);

        // Slow rate, then speed up with the count already past the new terminal.
        clkscale = 3'd6;
        step(40);
        check("slow_hold", {16'd0, dut.lfsr_q}, 32'h0000_670F);
        clkscale = 3'd7;
        step(1);
        check("rate_chg_lfsr", {16'd0, dut.lfsr_q}, 32'h0000_CE1E);
        check("rate_chg_step", {16'd0, dut.step_q}, 32'h0000_0004);
        step(31);
        check("after_chg_hold", {16'd0, dut.step_q}, 32'h0000_0004);
        step(1);
        check("after_chg_tick", {16'd0, dut.step_q}, 32'h0000_0005);

        // Mid-run reset takes effect on the next edge.
        reset = 1'b0;
        step(1);
        check("mid_rst_lfsr", {16'd0, dut.lfsr_q}, 32'h0000_ACE1);
        check("mid_rst_step", {16'd0, dut.step_q}, 32'h0000_0000);
        check("mid_rst_an",   {28'd0, an},         32'h0000_000E);
        check("mid_rst_sseg", {24'd0, sseg},       32'h0000_00F9);

        // Full period on the fast instance.
        reset2    = 1'b1;
        seen_zero = 1'b0;
        step(1);
        check("fast_tick1", {16'd0, dut2.lfsr_q}, 32'h0000_59C3);
        for (int i = 1; i < 65535; i++) begin
            step(1);
            l2 = dut2.lfsr_q;
            if (l2 == 16'd0) seen_zero = 1'b1;
            if (i == 65533) check("fast_not_back_early", {31'd0, (l2 == 16'hACE1)}, 32'd0);
        end
        check("period_lfsr", {16'd0, dut2.lfsr_q}, 32'h0000_ACE1);
        check("period_step", {16'd0, dut2.step_q}, 32'h0000_FFFF);
        check("never_zero",  {31'd0, seen_zero},   32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
